// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        rx,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [4:0]  level,
  output logic        frame_err,
  output logic        overrun,
  input  logic        err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] FULL = 5'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic rx_s1_q, rx_s2_q, rx_d_q;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic brk_q, brk_d;
  logic tick, fall, start, st_smp, bit_smp, stop_smp, push, ferr_set;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [4:0] level_q, level_d;
  logic frame_err_q, overrun_q;
  logic full, pop, wr, ovr_set;
  assign tick = cnt_q == prescale;
  assign fall = rx_d_q && !rx_s2_q;
  assign start = (state_q == IDLE) && (state_d == START);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall) state_d = START;
      START: if (st_smp) state_d = rx_s2_q ? IDLE : DATA;
      DATA:  if (bit_smp && bit_q == 3'd7) state_d = STOP;
      STOP:  if ((brk_q || stop_smp) && rx_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end
  // A low stop bit parks the FSM in STOP (brk_q) until the line returns high
  always_comb begin
    st_smp   = en && state_q == START && tick && os_q == 4'd7;
    bit_smp  = en && state_q == DATA && tick && os_q == 4'd15;
    stop_smp = en && state_q == STOP && tick && os_q == 4'd15 && !brk_q;
    push     = stop_smp && rx_s2_q;
    ferr_set = stop_smp && !rx_s2_q;
  end
  always_comb begin
    cnt_d = (start || tick) ? 16'd0 : cnt_q + 16'd1;
    os_d  = (start || st_smp) ? 4'd0 : (tick && state_q != IDLE) ? os_q + 4'd1 : os_q;
    bit_d = start ? 3'd0 : bit_smp ? bit_q + 3'd1 : bit_q;
    sh_d  = bit_smp ? {rx_s2_q, sh_q[7:1]} : sh_q;
    brk_d = (state_d == STOP) && (brk_q || ferr_set);
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_d_q  <= 1'b1;
      cnt_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      brk_q   <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_d_q  <= rx_s2_q;
      cnt_q   <= cnt_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      brk_q   <= brk_d;
    end
  assign full    = level_q == FULL;
  assign pop     = rd_valid && rd_ready;
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign level_d = level_q + {4'd0, wr} - {4'd0, pop};
  always_ff @(posedge HCLK)
    if (wr) mem_q[wp_q] <= sh_q;
  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wp_q        <= '0;
      rp_q        <= '0;
      level_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wp_q        <= wp_q + AW'(wr);
      rp_q        <= rp_q + AW'(pop);
      level_q     <= level_d;
      frame_err_q <= ferr_set || (frame_err_q && !err_clr);
      overrun_q   <= ovr_set || (overrun_q && !err_clr);
    end
  assign rd_valid  = level_q != 5'd0;
  assign rd_data   = rd_valid ? mem_q[rp_q] : 8'h00;
  assign level     = level_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames checked against a queue-based receiver model
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  logic HCLK = 1'b0, HRESETn, en, rx, rd_ready, err_clr;
  logic [15:0] prescale;
  logic [7:0] rd_data;
  logic rd_valid, frame_err, overrun;
  logic [4:0] level;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mq[$];
  logic m_ferr, m_ovr;
  uart_rx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .prescale(prescale), .rx(rx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level),
    .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );
  always #5 HCLK = ~HCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One clock: a pop is modelled whenever the consumer is ready and the model holds data
  task automatic step(input logic rdy);
    rd_ready = rdy;
    if (rdy && mq.size() > 0) begin
      check("rd_data", 32'(rd_data), 32'(mq[0]));
      mq.delete(0);
    end
    @(posedge HCLK);
    #1;
    rd_ready = 1'b0;
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask
  task automatic send(input logic [7:0] d, input logic stp, input int pop_at, input logic rnd);
    logic [9:0] fr;
    logic r;
    fr = {stp, d, 1'b0};
    for (int k = 0; k < 160; k++) begin
      rx = fr[k/16];
      r = (k == pop_at);
      if (rnd && k < 140) r = 1'($urandom_range(0, 1));
      step(r);
    end
    if (!stp) m_ferr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovr = 1'b1;
  endtask
  task automatic clr_err();
    err_clr = 1'b1;
    step(1'b0);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
  endtask
  task automatic check_state(input string tag);
    check({tag, "_level"}, 32'(level), 32'(mq.size()));
    check({tag, "_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
    check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask
  initial begin
    logic [9:0] fr;
    logic [7:0] last;
    logic bad;
    HRESETn = 1'b0; en = 1'b1; prescale = 16'd0; rx = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
    m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    HRESETn = 1'b1;
    idle(5);
    send(8'h55, 1'b1, -1, 1'b0);
    send(8'hA3, 1'b1, -1, 1'b0);
    idle(2);
    check("two_level", 32'(level), 32'd2);
    check("two_head", 32'(rd_data), 32'h55);
    step(1'b1);
    check("two_second", 32'(rd_data), 32'hA3);
    step(1'b1);
    check("two_empty", 32'(rd_valid), 32'd0);
    rx = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0);
    idle(40);
    check("glitch_level", 32'(level), 32'd0);
    check("glitch_ferr", 32'(frame_err), 32'd0);
    send(8'h41, 1'b0, -1, 1'b0);
    idle(20);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_level", 32'(level), 32'd0);
    clr_err();
    check("ferr_clr", 32'(frame_err), 32'd0);
    send(8'h42, 1'b1, -1, 1'b0);
    idle(2);
    check("after_ferr_level", 32'(level), 32'd1);
    check("after_ferr_data", 32'(rd_data), 32'h42);
    step(1'b1);
    for (int i = 0; i < 9; i++) send(8'(i), 1'b1, -1, 1'b0);
    idle(2);
    check("ovr_level", 32'(level), 32'd8);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("ovr_drain", 32'(rd_data), 32'(i));
      step(1'b1);
    end
    check("ovr_empty", 32'(rd_valid), 32'd0);
    clr_err();
    check("ovr_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) send(8'(i), 1'b1, -1, 1'b0);
    send(8'h08, 1'b1, 154, 1'b0);
    idle(2);
    check("fullpop_ovr", 32'(overrun), 32'd0);
    check("fullpop_level", 32'(level), 32'd8);
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last = rd_data;
      step(1'b1);
    end
    check("fullpop_last", 32'(last), 32'h08);
    send(8'h11, 1'b1, -1, 1'b0);
    fr = {1'b1, 8'h99, 1'b0};
    for (int k = 0; k < 88; k++) begin
      rx = fr[k/16];
      step(1'b0);
    end
    HRESETn = 1'b0;
    rx = 1'b1;
    mq.delete();
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    #1;
    check("midrst_level", 32'(level), 32'd0);
    idle(3);
    HRESETn = 1'b1;
    idle(20);
    send(8'h7E, 1'b1, -1, 1'b0);
    idle(2);
    check("midrst_rx_level", 32'(level), 32'd1);
    check("midrst_rx_data", 32'(rd_data), 32'h7E);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);
    step(1'b1);
    for (int n = 0; n < 16; n++) begin
      bad = ($urandom_range(0, 5) == 0);
      send(8'($urandom), !bad, -1, 1'b1);
      if (bad) idle(20);
      else idle($urandom_range(0, 4));
      check_state("rnd");
    end
    while (mq.size() > 0) step(1'b1);
    check_state("rnd_drained");
    clr_err();
    check_state("rnd_cleared");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL expose parameter FIFO_DEPTH, default 8, receive FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have the port HCLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have the port HRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the port en, input, 1 bit: receiver enable.
REQ-005 The block SHALL have the port prescale, input, 16 bits: oversample tick divisor; one tick every prescale+1 HCLK cycles.
REQ-006 The block SHALL have the port rx, input, 1 bit: serial line (SoC RsTx); asynchronous; idles high.
REQ-007 The block SHALL have the port rd_data, output, 8 bits: head-of-FIFO byte.
REQ-008 The block SHALL have the port rd_valid, output, 1 bit: FIFO not empty.
REQ-009 The block SHALL have the port rd_ready, input, 1 bit: consumer accepts the head byte.
REQ-010 The block SHALL have the port level, output, 5 bits: current FIFO occupancy.
REQ-011 The block SHALL have the port frame_err, output, 1 bit: sticky; a stop bit was sampled low.
REQ-012 The block SHALL have the port overrun, output, 1 bit: sticky; a byte was dropped because the FIFO was full.
REQ-013 The block SHALL have the port err_clr, input, 1 bit: single-cycle pulse that clears frame_err and overrun.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value.
REQ-015 The tick counter SHALL count 0..prescale, emit a one-cycle tick at prescale, and restart from 0 on every IDLE->START transition.
REQ-016 The FSM SHALL have exactly four states, IDLE, START, DATA and STOP, with this behaviour:
- IDLE→START on a synchronized 1→0 edge while en=1.
- START samples rx at tick 8 (mid-bit): if 0, go to DATA; if 1, treat as a glitch and return to IDLE with no flag set.
- DATA samples every 16 ticks, LSB first; after the 8th bit, go to STOP.
REQ-017 In STOP, rx SHALL be sampled 16 ticks after the last data bit, with this behaviour:
- Sample 1: push the byte and go to IDLE.
- Sample 0: set frame_err, discard the byte, and stay in STOP until synchronized rx=1, then go to IDLE.
REQ-018 With prescale=0, one bit SHALL last 16 HCLK cycles, and rd_valid SHALL assert on the cycle after the stop-bit sample.
REQ-019 en=0 SHALL force the FSM to IDLE within one cycle, abandoning any partial byte, while FIFO contents and flags are retained.
REQ-020 The FIFO SHALL be first-word-fall-through: rd_valid=(level!=0), rd_data=head entry, and a pop occurs when rd_valid&&rd_ready.
REQ-021 A push while full without a simultaneous pop SHALL drop the new byte, set overrun, and leave the FIFO unchanged.
REQ-022 A push while full with a simultaneous pop SHALL be accepted, leaving level unchanged and overrun not set.
REQ-023 Simultaneous push and pop on an empty FIFO SHALL push only; the pop is not valid, so level becomes 1.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL saturate neither below 0 nor above FIFO_DEPTH.
REQ-025 If err_clr and a new error event occur in the same cycle, the flag SHALL end up set (set wins).
REQ-026 rd_ready asserted while rd_valid=0 SHALL have no effect.

Reset
REQ-027 On HRESETn=0, the block SHALL immediately enter the following state:
- FSM in IDLE.
- Tick counter, bit counter, shift register, pointers and level at 0.
- rd_valid=0, rd_data=0x00, frame_err=0, overrun=0.
- Synchronizer flops at 1.
REQ-028 Deassertion of reset SHALL take effect on the next HCLK rising edge; a frame in progress during reset SHALL be lost without setting any flag.

Verification
REQ-029 The bench SHALL cover the following scenarios, all with prescale=0, en=1 and a 16-cycle bit period unless stated otherwise:
- Send 0x55 then 0xA3 with rd_ready=0 → level=2 and rd_data=0x55; then pulse rd_ready twice → 0xA3 is read, then rd_valid=0.
- Drive rx low for 5 cycles, then high → no byte received, level=0, frame_err=0.
- Send 0x41 with the stop bit low, then idle → frame_err=1 and level=0; pulse err_clr → frame_err=0; a subsequent 0x42 is received correctly.
- Send 9 bytes 0x00..0x08 with rd_ready=0 → level=8, overrun=1, and the drain order is 0x00..0x07.
- With the FIFO full, assert rd_ready at the 9th byte's stop sample → overrun=0, level=8, and the last byte read is 0x08.
- Assert HRESETn=0 mid-byte (during DATA bit 4), then release and send 0x7E → only 0x7E is received, with flags 0.
